// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush/stall controller.
// Enumerator names follow the encodings the datapath decodes directly.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

    localparam int unsigned XZR = 31;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding source select for one EX operand: the MEM-stage result wins over the WB result,
// and the zero register is never forwarded.
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] srcReg,
    input  logic [RA_W-1:0] memRd,
    input  logic            memWrite,
    input  logic [RA_W-1:0] wbRd,
    input  logic            wbWrite,
    output fwd_t            fwdSel
);

    localparam logic [RA_W-1:0] ZeroReg = RA_W'(XZR);

    always_comb begin
        fwdSel = FWD_REG;
        if (srcReg != ZeroReg) begin
            if (memWrite && (memRd == srcReg)) begin
                fwdSel = FWD_MEM;
            end else if (wbWrite && (wbRd == srcReg)) begin
                fwdSel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, flush and stall controller: drives every pipeline-register enable/flush, tracks
// per-register valid bits, resolves forwarding and keeps saturating performance counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter  int unsigned STAGES     = 5,
    parameter  int unsigned RA_W       = 5,
    parameter  int unsigned BRANCH_REG = 2,
    parameter  int unsigned CNT_W      = 32,
    localparam int unsigned NREG       = STAGES - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  ex_rs1,
    input  logic [RA_W-1:0]  ex_rs2,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_memRead,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_regWrite,
    input  logic             mem_memAccess,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             wb_regWrite,
    input  logic             branch_taken,
    input  logic             dmem_ready,
    output logic             pc_enable,
    output logic [NREG-1:0]  reg_enable,
    output logic [NREG-1:0]  reg_flush,
    output logic [NREG-1:0]  reg_valid,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [RA_W-1:0] ZeroReg = RA_W'(XZR);
    localparam int unsigned     ExReg   = 1;
    localparam int unsigned     MemReg  = 2;
    localparam int unsigned     WbReg   = 3;

    state_t           stateQ, stateD;
    logic [NREG-1:0]  validQ, validD, prevValid;
    logic [CNT_W-1:0] stallCntQ, stallCntD, flushCntQ, flushCntD;
    logic             memHold, freeze, branchHit, redirect, loadUse;
    fwd_t             fwdA, fwdB;

    always_comb begin
        memHold   = validQ[MemReg] && mem_memAccess && !dmem_ready;
        branchHit = branch_taken && validQ[BRANCH_REG];
        loadUse   = validQ[ExReg] && ex_memRead && (ex_rd != ZeroReg)
                    && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

        // The cycle that enters MEM_WAIT is already frozen; the ready cycle is not.
        stateD = stateQ;
        freeze = 1'b0;
        unique case (stateQ)
            RUN: begin
                freeze = memHold;
                if (memHold) stateD = MEM_WAIT;
            end
            MEM_WAIT: begin
                freeze = !dmem_ready;
                if (dmem_ready) stateD = RUN;
            end
            default: stateD = RUN;
        endcase

        pc_enable  = 1'b1;
        reg_enable = '1;
        reg_flush  = '0;
        stall      = 1'b0;
        redirect   = 1'b0;
        if (freeze) begin
            pc_enable  = 1'b0;
            reg_enable = '0;
        end else if (branchHit) begin
            redirect = 1'b1;
            for (int i = 0; i < int'(NREG); i++) begin
                if (i <= int'(BRANCH_REG)) reg_flush[i] = 1'b1;
            end
        end else if (loadUse) begin
            stall         = 1'b1;
            pc_enable     = 1'b0;
            reg_enable[0] = 1'b0;
            reg_flush[1]  = 1'b1;
        end

        // R0 fills with a fresh instruction; every later register takes its predecessor.
        prevValid = {validQ[NREG-2:0], 1'b1};
        validD    = validQ;
        for (int i = 0; i < int'(NREG); i++) begin
            if (reg_flush[i]) begin
                validD[i] = 1'b0;
            end else if (reg_enable[i]) begin
                validD[i] = prevValid[i];
            end
        end

        stallCntD = stallCntQ;
        if ((stall || freeze) && (stallCntQ != '1)) stallCntD = stallCntQ + CNT_W'(1);
        flushCntD = flushCntQ;
        if (redirect && (flushCntQ != '1)) flushCntD = flushCntQ + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= RUN;
            validQ    <= '0;
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            validQ    <= validD;
            stallCntQ <= stallCntD;
            flushCntQ <= flushCntD;
        end
    end

    pipe_fwd_sel #(.RA_W(RA_W)) u_fwdA (
        .srcReg   (ex_rs1),
        .memRd    (mem_rd),
        .memWrite (validQ[MemReg] && mem_regWrite),
        .wbRd     (wb_rd),
        .wbWrite  (validQ[WbReg] && wb_regWrite),
        .fwdSel   (fwdA)
    );

    pipe_fwd_sel #(.RA_W(RA_W)) u_fwdB (
        .srcReg   (ex_rs2),
        .memRd    (mem_rd),
        .memWrite (validQ[MemReg] && mem_regWrite),
        .wbRd     (wb_rd),
        .wbWrite  (validQ[WbReg] && wb_regWrite),
        .fwdSel   (fwdB)
    );

    assign forwardA     = fwdA;
    assign forwardB     = fwdB;
    assign reg_valid    = validQ;
    assign stall_cycles = stallCntQ;
    assign flush_events = flushCntQ;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: forwarding vector table, hand-built hazard sequences
// and randomized traffic against a rule-level reference model.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_memRead, mem_regWrite, mem_memAccess, wb_regWrite, branch_taken, dmem_ready;

    logic        pcEn, stall;
    logic [3:0]  regEn, regFl, regVal;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] stallCnt, flushCnt;

    logic        satPcEn, satStall;
    logic [3:0]  satEn, satFl, satVal;
    logic [1:0]  satFa, satFb;
    logic [2:0]  satStallCnt, satFlushCnt;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memRead(ex_memRead), .mem_rd(mem_rd),
        .mem_regWrite(mem_regWrite), .mem_memAccess(mem_memAccess), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .branch_taken(branch_taken), .dmem_ready(dmem_ready),
        .pc_enable(pcEn), .reg_enable(regEn), .reg_flush(regFl), .reg_valid(regVal),
        .forwardA(fwdA), .forwardB(fwdB), .stall(stall), .stall_cycles(stallCnt),
        .flush_events(flushCnt)
    );

    // Narrow counters so saturation is reachable.
    pipeline_ctrl #(.CNT_W(3)) dutSat (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memRead(ex_memRead), .mem_rd(mem_rd),
        .mem_regWrite(mem_regWrite), .mem_memAccess(mem_memAccess), .wb_rd(wb_rd),
        .wb_regWrite(wb_regWrite), .branch_taken(branch_taken), .dmem_ready(dmem_ready),
        .pc_enable(satPcEn), .reg_enable(satEn), .reg_flush(satFl), .reg_valid(satVal),
        .forwardA(satFa), .forwardB(satFb), .stall(satStall), .stall_cycles(satStallCnt),
        .flush_events(satFlushCnt)
    );

    int nChecks = 0;
    int nErrors = 0;

    bit [3:0]        mValid;
    bit              mWait;
    longint unsigned mStallN, mFlushN;

    logic [3:0] snapEn, snapFl;
    logic       snapPc, snapStall;
    logic [1:0] snapFa, snapFb;

    typedef struct {
        logic [4:0] exRs1, exRs2, memRd;
        logic       memWr;
        logic [4:0] wbRd;
        logic       wbWr;
        logic [1:0] fa, fb;
    } fvec_t;
    fvec_t fv[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint unsigned satv(input longint unsigned n, input int w);
        longint unsigned lim = (64'd1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    function automatic logic [1:0] fwdRef(input logic [4:0] rs);
        if (rs == 5'd31) return 2'b00;
        if (mValid[2] && mem_regWrite && mem_rd == rs) return 2'b10;
        if (mValid[3] && wb_regWrite && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_memRead = 0; mem_regWrite = 0; mem_memAccess = 0; wb_regWrite = 0;
        branch_taken = 0; dmem_ready = 1;
    endtask

    task automatic modelReset();
        mValid = '0; mWait = 0; mStallN = 0; mFlushN = 0;
    endtask

    // Compare one cycle against the model, then clock it and advance the model.
    task automatic step();
        bit fr, rd, lu, ePc;
        logic [3:0] eEn, eFl, nV;
        logic [1:0] eFa, eFb;
        #2;
        fr = mWait ? !dmem_ready : (mValid[2] && mem_memAccess && !dmem_ready);
        rd = !fr && branch_taken && mValid[2];
        lu = !fr && !rd && mValid[1] && ex_memRead && ex_rd != 5'd31
             && (ex_rd == id_rs1 || ex_rd == id_rs2);
        eEn = fr ? 4'b0000 : (lu ? 4'b1110 : 4'b1111);
        eFl = rd ? 4'b0111 : (lu ? 4'b0010 : 4'b0000);
        ePc = !fr && !lu;
        eFa = fwdRef(ex_rs1);
        eFb = fwdRef(ex_rs2);
        check("enable", regEn, eEn);
        check("flush", regFl, eFl);
        check("valid", regVal, mValid);
        check("pc_enable", pcEn, ePc);
        check("stall", stall, lu);
        check("forwardA", fwdA, eFa);
        check("forwardB", fwdB, eFb);
        check("stall_cycles", stallCnt, satv(mStallN, 32));
        check("flush_events", flushCnt, satv(mFlushN, 32));
        check("sat_ctrl", {satEn, satFl, satVal, satPcEn, satStall, satFa, satFb},
              {eEn, eFl, mValid, ePc, lu, eFa, eFb});
        check("sat_stall_cycles", satStallCnt, satv(mStallN, 3));
        check("sat_flush_events", satFlushCnt, satv(mFlushN, 3));
        snapEn = regEn; snapFl = regFl; snapPc = pcEn; snapStall = stall;
        snapFa = fwdA; snapFb = fwdB;
        if (fr) nV = mValid;
        else if (rd) nV = {mValid[2], 3'b000};
        else if (lu) nV = {mValid[2], mValid[1], 1'b0, mValid[0]};
        else nV = {mValid[2:0], 1'b1};
        @(posedge clk);
        mValid = nV;
        mWait = fr;
        if (fr || lu) mStallN++;
        if (rd) mFlushN++;
        #1;
    endtask

    function automatic logic [4:0] pickReg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    endfunction

    initial begin
        longint unsigned s0, f0;
        fv[0] = '{5'd1, 5'd1, 5'd1, 1'b1, 5'd5, 1'b0, 2'b10, 2'b10};
        fv[1] = '{5'd1, 5'd1, 5'd31, 1'b1, 5'd5, 1'b0, 2'b00, 2'b00};
        fv[2] = '{5'd2, 5'd3, 5'd2, 1'b1, 5'd3, 1'b1, 2'b10, 2'b01};
        fv[3] = '{5'd4, 5'd4, 5'd4, 1'b1, 5'd4, 1'b1, 2'b10, 2'b10};
        fv[4] = '{5'd4, 5'd5, 5'd4, 1'b0, 5'd4, 1'b1, 2'b01, 2'b00};
        fv[5] = '{5'd31, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 2'b00, 2'b00};

        idle();
        reset = 1'b0;
        modelReset();
        #12;
        check("reset_valid", regVal, 4'b0000);
        check("reset_enable", {pcEn, regEn, regFl, stall}, {1'b1, 4'b1111, 4'b0000, 1'b0});
        check("reset_counters", {stallCnt, flushCnt}, 64'd0);
        reset = 1'b1;

        repeat (4) step();
        check("filled", regVal, 4'b1111);

        foreach (fv[i]) begin
            idle();
            ex_rs1 = fv[i].exRs1; ex_rs2 = fv[i].exRs2; mem_rd = fv[i].memRd;
            mem_regWrite = fv[i].memWr; wb_rd = fv[i].wbRd; wb_regWrite = fv[i].wbWr;
            step();
            check($sformatf("vec%0d_fwd", i), {snapFa, snapFb}, {fv[i].fa, fv[i].fb});
        end

        // LDUR X1 followed by ADD X2,X1,X3
        idle(); id_rs1 = 1; id_rs2 = 3; ex_memRead = 1; ex_rd = 1;
        step();
        check("lu_stall", {snapStall, snapPc, snapFl}, {1'b1, 1'b0, 4'b0010});
        idle(); id_rs1 = 1; id_rs2 = 3; mem_rd = 1; mem_regWrite = 1;
        step();
        check("lu_one_cycle", snapStall, 1'b0);
        idle(); ex_rs1 = 1; ex_rs2 = 3; wb_rd = 1; wb_regWrite = 1;
        step();
        check("lu_forward_wb", snapFa, 2'b01);

        // Taken branch in R2
        repeat (2) begin idle(); step(); end
        f0 = flushCnt;
        idle(); branch_taken = 1;
        step();
        check("br_flush", {snapFl, snapPc}, {4'b0111, 1'b1});
        step();
        check("br_once", snapFl, 4'b0000);
        check("br_count", flushCnt - f0, 64'd1);

        // Three-cycle memory freeze
        idle(); repeat (4) step();
        s0 = stallCnt;
        idle(); mem_memAccess = 1; dmem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("freeze%0d_en", c), {snapEn, snapPc, snapFl}, 9'd0);
        end
        dmem_ready = 1;
        step();
        check("freeze_resume", snapEn, 4'b1111);
        check("freeze_count", stallCnt - s0, 64'd3);

        // Freeze overlapping a taken branch
        idle(); repeat (4) step();
        f0 = flushCnt;
        idle(); mem_memAccess = 1; dmem_ready = 0; branch_taken = 1;
        repeat (2) begin
            step();
            check("ovl_no_flush", snapFl, 4'b0000);
        end
        dmem_ready = 1;
        step();
        check("ovl_redirect", snapFl, 4'b0111);
        mem_memAccess = 0;
        step();
        check("ovl_single", flushCnt - f0, 64'd1);

        // Asynchronous reset with the pipeline full
        idle(); repeat (4) step();
        ex_rs1 = 2; mem_rd = 2; mem_regWrite = 1;
        reset = 1'b0;
        #1;
        check("midrst_valid", regVal, 4'b0000);
        check("midrst_counters", {stallCnt, flushCnt}, 64'd0);
        check("midrst_fwd", fwdA, 2'b00);
        modelReset();
        #1;
        reset = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            id_rs1 = pickReg(); id_rs2 = pickReg(); ex_rs1 = pickReg(); ex_rs2 = pickReg();
            ex_rd = pickReg(); mem_rd = pickReg(); wb_rd = pickReg();
            ex_memRead = 1'($urandom_range(0, 1));
            mem_regWrite = 1'($urandom_range(0, 1));
            wb_regWrite = 1'($urandom_range(0, 1));
            mem_memAccess = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 5) == 0);
            dmem_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        check("sat_stall_pinned", satStallCnt, 3'd7);
        check("sat_flush_pinned", satFlushCnt, 3'd7);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
